// File: rtl/count_seq_ctrl.sv
// Up/down count sequencer: loads a start value, steps toward a terminal value,
// and signals completed passes in one-shot, auto-reload or ping-pong mode.
module count_seq_ctrl #(
   parameter int WIDTH  = 4,
   parameter int PASS_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              m,
   input  logic [1:0]        mode,
   input  logic [WIDTH-1:0]  init_val,
   input  logic [WIDTH-1:0]  term_val,
   output logic [WIDTH-1:0]  q,
   output logic              busy,
   output logic              done,
   output logic              dir,
   output logic [PASS_W-1:0] pass_cnt
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [1:0] MODE_RELOAD = 2'b01;
   localparam logic [1:0] MODE_PING   = 2'b10;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    q_q, q_d;
   logic [WIDTH-1:0]    tgt_q, tgt_d;
   logic [WIDTH-1:0]    init_q, init_d;
   logic [WIDTH-1:0]    term_q, term_d;
   logic [1:0]          mode_q, mode_d;
   logic                dir_q, dir_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [PASS_W-1:0]   pass_q, pass_d;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      tgt_d   = tgt_q;
      init_d  = init_q;
      term_d  = term_q;
      mode_d  = mode_q;
      dir_d   = dir_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               q_d     = init_val;
               dir_d   = m;
               tgt_d   = term_val;
               init_d  = init_val;
               term_d  = term_val;
               mode_d  = mode;
               pass_d  = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (!pause) begin
               if (q_q != tgt_q) begin
                  q_d = dir_q ? q_q - 1'b1 : q_q + 1'b1;
               end else begin
                  done_d = 1'b1;
                  if (pass_q != '1) pass_d = pass_q + 1'b1;
                  case (mode_q)
                     MODE_RELOAD: q_d = init_q;
                     MODE_PING: begin
                        // q dwells at the endpoint for this edge; next pass heads back
                        dir_d = ~dir_q;
                        tgt_d = (tgt_q == term_q) ? init_q : term_q;
                     end
                     default: begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                     end
                  endcase
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         tgt_q   <= '0;
         init_q  <= '0;
         term_q  <= '0;
         mode_q  <= '0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         tgt_q   <= tgt_d;
         init_q  <= init_d;
         term_q  <= term_d;
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign q        = q_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign dir      = dir_q;
   assign pass_cnt = pass_q;

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
- Sequencer for a WIDTH-bit up/down counter datapath.
- Loads a start value, steps the counter toward a terminal value one step per clock, and signals completion.
- Modes: one-shot, auto-reload and ping-pong, with pause and abort.
- Sits between control logic (start/stop handshake) and anything consuming the count (timers, address stepping, display scan).

Parameters:
- WIDTH, 4: counter width in bits.
- PASS_W, 8: width of the completed-pass counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle start request; honoured only in IDLE.
- stop  in  1  abort; returns to IDLE with no done pulse.
- pause  in  1  level; freezes the count while high in RUN.
- m  in  1  initial direction (0 = up, 1 = down); sampled on accepted start.
- mode  in  2  00 one-shot, 01 auto-reload, 10 ping-pong, 11 treated as one-shot; sampled on accepted start.
- init_val  in  WIDTH  start value; sampled on accepted start.
- term_val  in  WIDTH  terminal value; sampled on accepted start.
- q  out  WIDTH  current count.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse per completed pass.
- dir  out  1  current direction.
- pass_cnt  out  PASS_W  completed passes since last start; saturates at all-ones.

Behaviour:
- States: IDLE, RUN.
- Reset (rst = 0 at an edge), from any state and mid-run:
  - state IDLE; q = 0, busy = 0, done = 0, dir = 0, pass_cnt = 0.
  - internal latched init/term/target/mode = 0.
- Priority per edge: reset > stop > start/terminal/pause > step.
- done defaults to 0 every cycle; it is set only on a terminal edge.
- IDLE: q holds its value. If start = 1 and stop = 0:
  - q <= init_val; dir <= m; tgt <= term_val; latch init_val and mode.
  - pass_cnt <= 0; busy <= 1; go to RUN.
- IDLE, start and stop in the same cycle: stop wins; stay in IDLE.
- RUN, stop = 1: go to IDLE; busy <= 0; q holds; no done pulse; pass_cnt holds.
- RUN, pause = 1: q, dir and tgt hold; terminal check is suppressed.
- RUN, pause = 0, q != tgt: q <= q + 1 (dir = 0) or q - 1 (dir = 1), modulo 2^WIDTH. The counter wraps and never saturates (e.g. up from 14 toward 2 passes 15, 0, 1).
- RUN, pause = 0, q == tgt (terminal edge): done <= 1; pass_cnt <= pass_cnt + 1 (saturating); then by latched mode:
  - one-shot: go to IDLE; busy <= 0; q holds at tgt.
  - auto-reload: q <= latched init; stay in RUN; dir unchanged.
  - ping-pong: dir <= ~dir; tgt swaps between latched init and term; q holds for this edge (one-cycle dwell at each endpoint); stay in RUN.
- Latency:
  - q = init_val the cycle after an accepted start.
  - done asserts the cycle after q first equals tgt (a pass of N steps gives done N+1 edges after the start edge).
- init_val == term_val:
  - one-shot: done one edge after load.
  - auto-reload: q stays constant and done pulses every cycle.
  - ping-pong: dir toggles and done pulses every cycle.
- start while busy: ignored; latched values unchanged.
- Input changes to m/mode/init_val/term_val during RUN have no effect.

Test Plan:
- One-shot, WIDTH = 4: init = 3, term = 7, m = 0, start at edge 0 -> q = 3,4,5,6,7 after edges 0..4; done = 1 and busy = 0 after edge 5; q holds 7; pass_cnt = 1.
- Wrap, down: init = 1, term = 14, m = 1, one-shot -> q = 1,0,15,14; done after edge 4; dir = 1 throughout.
- Ping-pong: init = 2, term = 4, m = 0 -> q = 2,3,4,4,3,2,2,3; dir flips after edges 3 and 6; done pulses after edges 3 and 6; pass_cnt = 2 after edge 6.
- Auto-reload with pause: init = 0, term = 2 -> q = 0,1,2,0; pause high for 3 cycles when q = 1 -> q holds 1 and no done; resume -> 2 then reload 0 with done pulse.
- Abort and reset:
  - stop at q = 5 of a 3->9 run -> IDLE next edge, q = 5, busy = 0, no done.
  - start and stop in the same IDLE cycle -> remains IDLE.
  - rst = 0 mid-ping-pong -> all outputs 0 at the next edge.
- Ignored start / degenerate case:
  - start pulsed mid-run with different init -> sequence unaffected.
  - init = term = 6, one-shot -> q = 6 after edge 0; done after edge 1.
